// File: rtl/nmr_bstrm_seq_ctrl.sv
// Bitstream sequencer: walks SRAM 0..LAST_ADDR via the single-shot reader and plays {pattern,hold} words gapless.
// Latency: START in cycle 0 -> RD_START cycle 1 -> data cycle 4 -> first pattern cycle 5; DONE one cycle after the last pattern.
// Backpressure: RD_START waits for RD_SYS_RDY with one read outstanding; an empty shadow at word end holds the pattern and sets UNDERRUN.
//
// Ports: CLK/RST (async active-low); START/ABORT/LAST_ADDR host control, BUSY/DONE/UNDERRUN/ABORTED status;
//        BSTRM_OUT played pattern; SRAM_ADDR/RD_START/RD_SYS_RDY/RD_DATA_RDY/RD_DATA reader handshake.
// Optional: BSTRM_SEQ_LOOP_EN adds the LOOP input (wrap LAST_ADDR->0 while LOOP=1).
module nmr_bstrm_seq_ctrl #(
  parameter int SRAM_ADDR_WIDTH = 8,
  parameter int SRAM_DAT_WIDTH  = 32,
  parameter int OUT_WIDTH       = 8,
  localparam int CNT_WIDTH      = SRAM_DAT_WIDTH - OUT_WIDTH
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       START,
  input  logic                       ABORT,
  input  logic [SRAM_ADDR_WIDTH-1:0] LAST_ADDR,
`ifdef BSTRM_SEQ_LOOP_EN
  input  logic                       LOOP,
`endif
  output logic                       BUSY,
  output logic                       DONE,
  output logic                       UNDERRUN,
  output logic                       ABORTED,
  output logic [OUT_WIDTH-1:0]       BSTRM_OUT,
  output logic [SRAM_ADDR_WIDTH-1:0] SRAM_ADDR,
  output logic                       RD_START,
  input  logic                       RD_SYS_RDY,
  input  logic                       RD_DATA_RDY,
  input  logic [SRAM_DAT_WIDTH-1:0]  RD_DATA
);

  typedef enum logic [2:0] {S_IDLE, S_PRIME, S_RUN, S_FINISH, S_FLUSH} state_t;

  state_t                     r_state, w_nxt;
  logic [SRAM_ADDR_WIDTH-1:0] r_addr, r_last;
  logic                       r_more;      // addresses remain to be fetched
  logic                       r_outst;     // one read in flight
  logic                       r_sh_vld;
  logic [SRAM_DAT_WIDTH-1:0]  r_sh_dat;
  logic [OUT_WIDTH-1:0]       r_out;
  logic [CNT_WIDTH-1:0]       r_cnt;       // cycles left for the current word, including this one
  logic                       r_underrun, r_aborted;

  logic                       w_cap, w_last, w_want, w_rd_start, w_loop, w_start_ok;
  logic [OUT_WIDTH-1:0]       w_cap_pat, w_sh_pat;
  logic [CNT_WIDTH-1:0]       w_cap_cnt, w_sh_cnt;

`ifdef BSTRM_SEQ_LOOP_EN
  assign w_loop = LOOP;
`else
  assign w_loop = 1'b0;
`endif

  assign w_cap      = RD_DATA_RDY & r_outst;
  assign w_cap_pat  = RD_DATA[SRAM_DAT_WIDTH-1 -: OUT_WIDTH];
  assign w_cap_cnt  = RD_DATA[CNT_WIDTH-1:0];
  assign w_sh_pat   = r_sh_dat[SRAM_DAT_WIDTH-1 -: OUT_WIDTH];
  assign w_sh_cnt   = r_sh_dat[CNT_WIDTH-1:0];
  assign w_last     = (r_cnt == CNT_WIDTH'(1));
  assign w_start_ok = START & ~ABORT;
  // A full shadow (including a held terminator) blocks further prefetch.
  assign w_want     = r_more & ~r_outst &
                      ((r_state == S_PRIME) | ((r_state == S_RUN) & ~r_sh_vld));
  assign w_rd_start = w_want & RD_SYS_RDY & ~ABORT;

  // State register
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) r_state <= S_IDLE;
    else      r_state <= w_nxt;
  end

  // Next-state logic
  always_comb begin
    w_nxt = r_state;
    case (r_state)
      S_IDLE:   if (w_start_ok) w_nxt = S_PRIME;
      S_PRIME: begin
        if (ABORT)      w_nxt = S_FLUSH;
        else if (w_cap) w_nxt = (w_cap_cnt == '0) ? S_FINISH : S_RUN;
      end
      S_RUN: begin
        if (ABORT) w_nxt = S_FLUSH;
        else if (w_last) begin
          if (r_sh_vld)               w_nxt = (w_sh_cnt == '0) ? S_FINISH : S_RUN;
          else if (w_cap)             w_nxt = (w_cap_cnt == '0) ? S_FINISH : S_RUN;
          else if (!r_outst && !r_more) w_nxt = S_FINISH;
        end
      end
      S_FINISH: w_nxt = ABORT ? S_FLUSH : S_IDLE;
      S_FLUSH:  if (!r_outst || w_cap) w_nxt = S_IDLE;
      default:  w_nxt = S_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    BUSY      = (r_state == S_PRIME) | (r_state == S_RUN) | (r_state == S_FLUSH);
    DONE      = (r_state == S_FINISH) & ~ABORT;
    RD_START  = w_rd_start;
    BSTRM_OUT = r_out;
    SRAM_ADDR = r_addr;
    UNDERRUN  = r_underrun;
    ABORTED   = r_aborted;
  end

  // Fetch engine and playback datapath
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_addr     <= '0;
      r_last     <= '0;
      r_more     <= 1'b0;
      r_outst    <= 1'b0;
      r_sh_vld   <= 1'b0;
      r_sh_dat   <= '0;
      r_out      <= '0;
      r_cnt      <= '0;
      r_underrun <= 1'b0;
      r_aborted  <= 1'b0;
    end else begin
      if (w_rd_start)  r_outst <= 1'b1;
      else if (w_cap)  r_outst <= 1'b0;

      if (w_cap) begin
        if (r_addr == r_last) begin
          r_addr <= '0;
          if (!w_loop) r_more <= 1'b0;
        end else begin
          r_addr <= r_addr + SRAM_ADDR_WIDTH'(1);
        end
      end

      case (r_state)
        S_IDLE: if (w_start_ok) begin
          r_last     <= LAST_ADDR;
          r_addr     <= '0;
          r_more     <= 1'b1;
          r_underrun <= 1'b0;
          r_aborted  <= 1'b0;
          r_sh_vld   <= 1'b0;
          r_out      <= '0;
        end
        S_PRIME: if (w_cap && w_cap_cnt != '0) begin
          r_out <= w_cap_pat;
          r_cnt <= w_cap_cnt;
        end
        S_RUN: begin
          if (w_last) begin
            if (r_sh_vld) begin
              r_sh_vld <= 1'b0;
              r_out    <= (w_sh_cnt != '0) ? w_sh_pat : '0;
              r_cnt    <= w_sh_cnt;
            end else if (w_cap) begin
              // Data landed on the word's last cycle (or during a stall): play it directly.
              r_out <= (w_cap_cnt != '0) ? w_cap_pat : '0;
              r_cnt <= w_cap_cnt;
            end else if (r_outst || r_more) begin
              r_underrun <= 1'b1;   // hold pattern, r_cnt stays at 1
            end else begin
              r_out <= '0;
            end
          end else begin
            r_cnt <= r_cnt - CNT_WIDTH'(1);
            if (w_cap) begin
              r_sh_dat <= RD_DATA;
              r_sh_vld <= 1'b1;
            end
          end
        end
        default: r_out <= '0;
      endcase

      if (ABORT && r_state != S_IDLE) begin
        r_out     <= '0;
        r_aborted <= 1'b1;
        r_sh_vld  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_nmr_bstrm_seq_ctrl.sv
// Directed bench for nmr_bstrm_seq_ctrl with a behavioural single-shot reader (RD_START -> RD_DATA_RDY 3 cycles later).
// Cycle n of a run is counted from the cycle in which START is high (cycle 0); outputs are sampled on the falling edge.
// Optional loop scenario is compiled only with BSTRM_SEQ_LOOP_EN.
module tb_nmr_bstrm_seq_ctrl;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        START = 1'b0;
  logic        ABORT = 1'b0;
  logic [7:0]  LAST_ADDR = '0;
  logic        LOOP = 1'b0;
  logic        BUSY, DONE, UNDERRUN, ABORTED, RD_START;
  logic [7:0]  BSTRM_OUT, SRAM_ADDR;
  logic        RD_SYS_RDY, RD_DATA_RDY;
  logic [31:0] RD_DATA;

  nmr_bstrm_seq_ctrl dut (
    .CLK(CLK), .RST(RST), .START(START), .ABORT(ABORT), .LAST_ADDR(LAST_ADDR),
`ifdef BSTRM_SEQ_LOOP_EN
    .LOOP(LOOP),
`endif
    .BUSY(BUSY), .DONE(DONE), .UNDERRUN(UNDERRUN), .ABORTED(ABORTED),
    .BSTRM_OUT(BSTRM_OUT), .SRAM_ADDR(SRAM_ADDR), .RD_START(RD_START),
    .RD_SYS_RDY(RD_SYS_RDY), .RD_DATA_RDY(RD_DATA_RDY), .RD_DATA(RD_DATA)
  );

  always #5 CLK = ~CLK;

  // Reader model
  logic [31:0] mem [0:15];
  logic        rd_busy, rd_dly;
  assign RD_SYS_RDY = ~rd_busy;
  always @(posedge CLK or negedge RST) begin
    if (!RST) begin
      rd_busy <= 1'b0; rd_dly <= 1'b0; RD_DATA_RDY <= 1'b0; RD_DATA <= '0;
    end else begin
      RD_DATA_RDY <= 1'b0;
      if (rd_busy) begin
        if (!rd_dly) begin RD_DATA_RDY <= 1'b1; rd_busy <= 1'b0; end
        else rd_dly <= 1'b0;
      end else if (RD_START) begin
        rd_busy <= 1'b1; rd_dly <= 1'b1; RD_DATA <= mem[SRAM_ADDR[3:0]];
      end
    end
  end

  // Per-run trace
  int cyc = 0;
  int t0 = 1000000;
  always @(posedge CLK) cyc <= cyc + 1;

  logic [7:0] tr_out [0:63];
  logic       tr_busy [0:63];
  logic       tr_done [0:63];
  logic       tr_rds  [0:63];
  logic [7:0] rd_addr [0:15];
  int         rds_n = 0;
  int         done_cnt = 0;

  always @(negedge CLK) begin
    int rel;
    rel = cyc - t0;
    if (rel == 1) begin
      for (int i = 0; i < 64; i++) begin
        tr_out[i] = '0; tr_busy[i] = 1'b0; tr_done[i] = 1'b0; tr_rds[i] = 1'b0;
      end
      rds_n = 0; done_cnt = 0;
    end
    if (rel >= 1 && rel < 64) begin
      tr_out[rel] = BSTRM_OUT; tr_busy[rel] = BUSY; tr_done[rel] = DONE; tr_rds[rel] = RD_START;
    end
    if (rel >= 1) begin
      if (DONE) done_cnt++;
      if (RD_START && rds_n < 16) begin rd_addr[rds_n] = SRAM_ADDR; rds_n++; end
    end
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Expected playback built from a word table: patterns back-to-back from cycle 5.
  logic [7:0] w_pat [0:7];
  int         w_cnt [0:7];
  int         w_n;
  logic [7:0] exp_out [0:63];
  int         exp_end;

  task automatic build_exp();
    int pos;
    for (int i = 0; i < 64; i++) exp_out[i] = '0;
    pos = 5;
    for (int k = 0; k < w_n; k++)
      for (int j = 0; j < w_cnt[k]; j++) begin exp_out[pos] = w_pat[k]; pos++; end
    exp_end = pos;
  endtask

  task automatic start_seq(input logic ab);
    @(negedge CLK);
    START = 1'b1; ABORT = ab; t0 = cyc;
    @(negedge CLK);
    START = 1'b0; ABORT = 1'b0;
  endtask

  task automatic load_t1();
    mem[0] = {8'hA5, 24'd5}; mem[1] = {8'h3C, 24'd6}; mem[2] = {8'h0F, 24'd4}; mem[3] = '0;
    w_pat[0] = 8'hA5; w_cnt[0] = 5; w_pat[1] = 8'h3C; w_cnt[1] = 6; w_pat[2] = 8'h0F; w_cnt[2] = 4; w_n = 3;
    LAST_ADDR = 8'd2;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = '0;

    // Reset state
    repeat (2) @(negedge CLK);
    chk("rst_busy", BUSY, 0);
    chk("rst_done", DONE, 0);
    chk("rst_out", BSTRM_OUT, 0);
    chk("rst_addr", SRAM_ADDR, 0);
    chk("rst_rdstart", RD_START, 0);
    chk("rst_flags", {UNDERRUN, ABORTED}, 0);
    RST = 1'b1;
    repeat (2) @(negedge CLK);

    // 1: three contiguous words
    load_t1(); build_exp();
    start_seq(1'b0);
    repeat (28) @(negedge CLK); #1;
    chk("t1_rdstart_c1", tr_rds[1], 1);
    for (int r = 1; r < 26; r++) chk($sformatf("t1_out[%0d]", r), tr_out[r], exp_out[r]);
    chk("t1_done_c20", tr_done[20], 1);
    chk("t1_done_cnt", done_cnt, 1);
    chk("t1_busy_c19", tr_busy[19], 1);
    chk("t1_busy_c20", tr_busy[20], 0);
    chk("t1_underrun", UNDERRUN, 0);
    chk("t1_reads", rds_n, 3);
    for (int k = 0; k < 3; k++) chk($sformatf("t1_addr[%0d]", k), rd_addr[k], k);

    // 2: count-1 words underrun; each held until the next lands
    mem[0] = {8'h11, 24'd1}; mem[1] = {8'h22, 24'd1}; LAST_ADDR = 8'd1;
    start_seq(1'b0);
    repeat (20) @(negedge CLK); #1;
    for (int r = 5; r <= 8; r++) chk($sformatf("t2_out[%0d]", r), tr_out[r], 8'h11);
    chk("t2_out_c9", tr_out[9], 8'h22);
    chk("t2_out_c10", tr_out[10], 0);
    chk("t2_done_c10", tr_done[10], 1);
    chk("t2_done_cnt", done_cnt, 1);
    chk("t2_underrun", UNDERRUN, 1);

    // 3: terminator at word 1; addresses 2-3 never read; START clears UNDERRUN
    mem[0] = {8'h5A, 24'd4}; mem[1] = {8'hFF, 24'd0}; mem[2] = {8'h77, 24'd4}; mem[3] = {8'h88, 24'd4};
    LAST_ADDR = 8'd3;
    start_seq(1'b0);
    repeat (20) @(negedge CLK); #1;
    for (int r = 5; r <= 8; r++) chk($sformatf("t3_out[%0d]", r), tr_out[r], 8'h5A);
    chk("t3_out_c9", tr_out[9], 0);
    chk("t3_done_c9", tr_done[9], 1);
    chk("t3_done_cnt", done_cnt, 1);
    chk("t3_reads", rds_n, 2);
    chk("t3_addr1", rd_addr[1], 1);
    chk("t3_underrun", UNDERRUN, 0);

    // 4: ABORT two cycles after the prefetch RD_START (cycle 5)
    load_t1();
    start_seq(1'b0);
    repeat (6) @(negedge CLK);
    ABORT = 1'b1;
    @(negedge CLK);
    ABORT = 1'b0;
    repeat (16) @(negedge CLK); #1;
    chk("t4_out_c7", tr_out[7], 8'hA5);
    chk("t4_out_c8", tr_out[8], 0);
    chk("t4_out_c12", tr_out[12], 0);
    chk("t4_busy_c8", tr_busy[8], 1);
    chk("t4_busy_c9", tr_busy[9], 0);
    chk("t4_reads", rds_n, 2);
    chk("t4_done_cnt", done_cnt, 0);
    chk("t4_aborted", ABORTED, 1);

    // 5: START with ABORT while idle is ignored
    start_seq(1'b1);
    repeat (6) @(negedge CLK); #1;
    chk("t5_busy", tr_busy[1], 0);
    chk("t5_reads", rds_n, 0);
    chk("t5_aborted_kept", ABORTED, 1);

    // 6: asynchronous reset mid-RUN, then a normal sequence
    load_t1(); build_exp();
    start_seq(1'b0);
    repeat (6) @(negedge CLK);
    #2 RST = 1'b0;
    #1;
    chk("t6_rst_out", BSTRM_OUT, 0);
    chk("t6_rst_busy", BUSY, 0);
    chk("t6_rst_addr", SRAM_ADDR, 0);
    chk("t6_rst_flags", {DONE, RD_START, UNDERRUN, ABORTED}, 0);
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    start_seq(1'b0);
    repeat (28) @(negedge CLK); #1;
    for (int r = 1; r < 26; r++) chk($sformatf("t6_out[%0d]", r), tr_out[r], exp_out[r]);
    chk("t6_done_c20", tr_done[20], 1);

`ifdef BSTRM_SEQ_LOOP_EN
    // 7: loop over two words; LOOP dropped before the second wrap
    mem[0] = {8'h21, 24'd4}; mem[1] = {8'h42, 24'd4}; LAST_ADDR = 8'd1; LOOP = 1'b1;
    w_pat[0] = 8'h21; w_cnt[0] = 4; w_pat[1] = 8'h42; w_cnt[1] = 4;
    w_pat[2] = 8'h21; w_cnt[2] = 4; w_pat[3] = 8'h42; w_cnt[3] = 4; w_n = 4;
    build_exp();
    start_seq(1'b0);
    repeat (9) @(negedge CLK);
    LOOP = 1'b0;
    repeat (20) @(negedge CLK); #1;
    for (int r = 1; r < 26; r++) chk($sformatf("t7_out[%0d]", r), tr_out[r], exp_out[r]);
    chk("t7_done_c21", tr_done[21], 1);
    chk("t7_reads", rds_n, 4);
    for (int k = 0; k < 4; k++) chk($sformatf("t7_addr[%0d]", k), rd_addr[k], k % 2);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/nmr_bstrm_seq_ctrl.md
# nmr_bstrm_seq_ctrl

Sequencer for the NMR bitstream memory path. It walks a range of SRAM addresses and drives the single-shot SRAM reader through its START / SYS_RDY / DATA_RDY handshake. Each returned word is decoded as an output pattern plus a hold count, and the pattern is played on `BSTRM_OUT`. The next word is prefetched during playback so the output runs gapless. The block sits between the host control registers and the reader, and owns the SRAM address bus.

## Interface
- `SRAM_ADDR_WIDTH`, 8: SRAM address width.
- `SRAM_DAT_WIDTH`, 32: SRAM word width.
- `OUT_WIDTH`, 8: pattern bits, taken from word bits [SRAM_DAT_WIDTH-1 -: OUT_WIDTH].
- `CNT_WIDTH`, derived as SRAM_DAT_WIDTH-OUT_WIDTH: hold-count field, word bits [CNT_WIDTH-1:0].
- `CLK` in 1: the only clock.
- `RST` in 1: asynchronous, active-low reset.
- `START` in 1: one-cycle pulse that begins a sequence; ignored unless idle.
- `ABORT` in 1: level; stops the sequence.
- `LAST_ADDR` in SRAM_ADDR_WIDTH: last address played; sampled on START.
- `LOOP` in 1: present only with `BSTRM_SEQ_LOOP_EN`.
- `BUSY` out 1: high from START acceptance until return to IDLE.
- `DONE` out 1: one-cycle pulse at normal completion.
- `UNDERRUN` out 1: sticky; cleared on START.
- `ABORTED` out 1: sticky; cleared on START.
- `BSTRM_OUT` out OUT_WIDTH: played pattern.
- `SRAM_ADDR` out SRAM_ADDR_WIDTH: read address to SRAM.
- `RD_START` out 1: one-cycle request to the reader.
- `RD_SYS_RDY` in 1: reader idle.
- `RD_DATA_RDY` in 1: one-cycle read-data-valid from the reader.
- `RD_DATA` in SRAM_DAT_WIDTH: reader data.

## Operation
- Reset values: all outputs 0; FSM in IDLE; shadow buffer empty.
- FSM states:
  - IDLE: START latches LAST_ADDR, sets addr=0, clears the sticky flags, then goes to PRIME.
  - PRIME: fetches word 0. Count≠0 goes to RUN; count=0 goes to FINISH.
  - RUN: plays the current word.
  - FINISH: pulses DONE, then goes to IDLE.
  - FLUSH: abort path.
- Fetch engine:
  - Issues RD_START only when RD_SYS_RDY=1 and no read is outstanding.
  - At most one read outstanding at a time.
  - The word is captured on RD_DATA_RDY.
  - addr increments on capture.
  - addr wraps LAST_ADDR→0 only in loop mode.
- Playback:
  - A word with count N≥1 drives its pattern for exactly N cycles.
  - During RUN, the next word is prefetched into a one-entry shadow buffer whenever the shadow is empty and addresses remain.
  - On the last cycle of the current word with the shadow valid, the shadow loads next cycle with no gap.
  - If the shadow is empty at that point, the last pattern is held, UNDERRUN is set, and playback resumes the cycle after the data lands.
- Count=0 is a terminator. The current word completes, then FINISH; the terminator pattern is never driven.
- If addresses are exhausted and the shadow is empty after the current word, go to FINISH.
- In FINISH and IDLE, BSTRM_OUT=0.
- ABORT in any non-IDLE state:
  - BSTRM_OUT=0 next cycle and no new RD_START is issued.
  - Go to FLUSH; any outstanding read is awaited and discarded, then go to IDLE.
  - Set ABORTED; no DONE pulse.
- ABORT and START in the same cycle while in IDLE: START is ignored.

## Timing
- START at cycle 0 → RD_START cycle 1, given RD_SYS_RDY=1; otherwise RD_START waits for it.
- Reader returns RD_DATA_RDY in cycle 4.
- First pattern is driven from cycle 5.
- SRAM_ADDR is stable from the RD_START cycle through the RD_DATA_RDY cycle.
- Fetch round trip is 4 cycles. Steady-state gapless playback requires every count ≥4; a count <4 may underrun.
- DONE is asserted in the cycle after the last pattern cycle; BUSY falls in that same cycle.
- Hold counter width is CNT_WIDTH; no saturation needed. Maximum hold is 2^CNT_WIDTH−1.

## Configuration
- `BSTRM_SEQ_LOOP_EN` defined:
  - `LOOP` port exists.
  - With LOOP=1, addr wraps LAST_ADDR→0 and prefetch continues across the wrap without a gap.
  - A terminator word or ABORT still ends the sequence.
  - LOOP is sampled at each wrap.
- Macro undefined: no `LOOP` port, and the sequence always ends after LAST_ADDR.

## Test plan
- Three words at addresses 0–2: {0xA5,5}, {0x3C,6}, {0x0F,4}, LAST_ADDR=2, START → A5 for 5 cycles, 3C for 6, 0F for 4, all contiguous. A5 starts at cycle 5, DONE 1 cycle after the last 0F, UNDERRUN=0.
- Words {0x11,1}, {0x22,1} → UNDERRUN=1, each pattern held until the next word lands, sequence still completes with DONE.
- Word 1 = {0xFF,0} with LAST_ADDR=3 → only word 0 is played, DONE follows, addresses 2–3 are never read.
- ABORT asserted 2 cycles after RD_START → BSTRM_OUT=0 next cycle, no further RD_START, IDLE after RD_DATA_RDY, ABORTED=1, DONE never pulses.
- Asynchronous RST mid-RUN → all outputs 0 immediately; next START is accepted normally.
- With `BSTRM_SEQ_LOOP_EN`, LOOP=1, LAST_ADDR=1, counts 4 → SRAM_ADDR sequence 0,1,0,1… with gapless output. Dropping LOOP ends the sequence after address 1.
